// File: rtl/scumv_tl_pkg.sv
// TileLink-UL opcode constants and the FSM state type for the tuning-register master.
package scumv_tl_pkg;

  localparam logic [2:0] A_PUT_FULL        = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] A_GET             = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [1:0] SIZE_WORD         = 2'd2;

  typedef enum logic [1:0] {IDLE, A_REQ, D_WAIT, RSP} state_e;

endpackage

// File: rtl/scumv_tuning_tl_master.sv
// Single-outstanding TileLink-UL master that turns cmd requests into word Get/Put accesses.
// state  | meaning
// IDLE   | accept a command
// A_REQ  | present A beat until accepted
// D_WAIT | wait for D beat or timeout
// RSP    | hold response until consumed
module scumv_tuning_tl_master
  import scumv_tl_pkg::*;
#(
  parameter int SOURCE_ID      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        tl_a_valid,
  input  logic        tl_a_ready,
  output logic [2:0]  tl_a_opcode,
  output logic [2:0]  tl_a_param,
  output logic [1:0]  tl_a_size,
  output logic [15:0] tl_a_source,
  output logic [15:0] tl_a_address,
  output logic [3:0]  tl_a_mask,
  output logic [31:0] tl_a_data,
  output logic        tl_a_corrupt,
  input  logic        tl_d_valid,
  output logic        tl_d_ready,
  input  logic [2:0]  tl_d_opcode,
  input  logic [1:0]  tl_d_size,
  input  logic [15:0] tl_d_source,
  input  logic [31:0] tl_d_data
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   SRC      = 16'(SOURCE_ID);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_write;
  logic [15:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_mask;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rsp_data;
  logic          r_rsp_error;

  logic          w_cmd_fire;
  logic          w_a_fire;
  logic          w_d_fire;
  logic          w_timeout;
  logic          w_d_err;
  logic [2:0]    w_d_exp_op;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    tl_a_valid  = 1'b0;
    tl_d_ready  = 1'b1;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = A_REQ;
      end
      A_REQ: begin
        tl_a_valid = 1'b1;
        tl_d_ready = 1'b0;
        if (tl_a_ready) w_state_nxt = D_WAIT;
      end
      D_WAIT: begin
        if (tl_d_valid || w_timeout) w_state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign w_a_fire   = tl_a_valid & tl_a_ready;
  assign w_d_fire   = (r_state == D_WAIT) & tl_d_valid & tl_d_ready;
  assign w_timeout  = (r_state == D_WAIT) && (r_cnt == CNT_LAST);
  assign w_d_exp_op = r_write ? D_ACCESS_ACK : D_ACCESS_ACK_DATA;
  assign w_d_err    = (tl_d_opcode != w_d_exp_op) | (tl_d_source != SRC) |
                      (tl_d_size != SIZE_WORD);

  // A-channel fields come straight from the command registers so they stay stable while stalled.
  assign tl_a_opcode  = !r_write ? A_GET : ((r_mask == 4'hF) ? A_PUT_FULL : A_PUT_PARTIAL);
  assign tl_a_param   = 3'd0;
  assign tl_a_size    = SIZE_WORD;
  assign tl_a_source  = SRC;
  assign tl_a_address = r_addr;
  assign tl_a_mask    = r_write ? r_mask : 4'hF;
  assign tl_a_data    = r_write ? r_wdata : 32'd0;
  assign tl_a_corrupt = 1'b0;

  assign rsp_data  = r_rsp_data;
  assign rsp_error = r_rsp_error;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_write     <= 1'b0;
      r_addr      <= 16'd0;
      r_wdata     <= 32'd0;
      r_mask      <= 4'd0;
      r_cnt       <= '0;
      r_rsp_data  <= 32'd0;
      r_rsp_error <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_write <= cmd_write;
        r_addr  <= {cmd_addr[15:2], 2'b00};
        r_wdata <= cmd_data;
        r_mask  <= cmd_mask;
      end
      if (w_a_fire)
        r_cnt <= '0;
      else if ((r_state == D_WAIT) && !w_d_fire)
        r_cnt <= r_cnt + CW'(1);
      // A D beat landing on the last timeout cycle still wins.
      if (w_d_fire) begin
        r_rsp_data  <= r_write ? 32'd0 : tl_d_data;
        r_rsp_error <= w_d_err;
      end else if (w_timeout) begin
        r_rsp_data  <= 32'd0;
        r_rsp_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scumv_tuning_tl_master.sv
// Directed bench: stimulus pushes expected A beats and responses; negedge monitors pop and compare.
module tb_scumv_tuning_tl_master;

  localparam int SRC = 3;
  localparam int TO  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_mask;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_data;
  logic        tl_a_valid, tl_a_ready, tl_a_corrupt;
  logic [2:0]  tl_a_opcode, tl_a_param;
  logic [1:0]  tl_a_size;
  logic [15:0] tl_a_source, tl_a_address;
  logic [3:0]  tl_a_mask;
  logic [31:0] tl_a_data;
  logic        tl_d_valid, tl_d_ready;
  logic [2:0]  tl_d_opcode;
  logic [1:0]  tl_d_size;
  logic [15:0] tl_d_source;
  logic [31:0] tl_d_data;

  scumv_tuning_tl_master #(.SOURCE_ID(SRC), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
    .tl_a_param(tl_a_param), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
    .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
    .tl_a_corrupt(tl_a_corrupt),
    .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
    .tl_d_size(tl_d_size), .tl_d_source(tl_d_source), .tl_d_data(tl_d_data)
  );

  always #5 clk = ~clk;

  typedef logic [76:0] a_t;
  a_t          a_q[$];
  logic [32:0] r_q[$];
  int          checks = 0;
  int          errors = 0;
  int          a_hs = 0;
  logic        a_pend = 1'b0, r_pend = 1'b0;
  a_t          a_held;
  logic [32:0] r_held;
  a_t          a_cur;
  logic [32:0] r_cur;

  assign a_cur = {tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address,
                  tl_a_mask, tl_a_data, tl_a_corrupt};
  assign r_cur = {rsp_data, rsp_error};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic a_t mk_a(input logic [2:0] op, input logic [15:0] addr,
                              input logic [3:0] m, input logic [31:0] d);
    return {op, 3'd0, 2'd2, 16'(SRC), addr, m, d, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      a_pend = 1'b0;
      r_pend = 1'b0;
    end else begin
      if (tl_a_valid) begin
        if (a_pend) chk("a_stable", a_cur, a_held);
        a_held = a_cur;
        if (tl_a_ready) begin
          a_hs++;
          a_pend = 1'b0;
          if (a_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected: got %0h expected none", a_cur);
          end else chk("a_fields", a_cur, a_q.pop_front());
        end else a_pend = 1'b1;
      end else if (a_pend) begin
        checks++; errors++;
        $display("FAIL a_valid_drop: got 0 expected 1");
        a_pend = 1'b0;
      end
      if (rsp_valid) begin
        if (r_pend) chk("rsp_stable", r_cur, r_held);
        r_held = r_cur;
        if (rsp_ready) begin
          r_pend = 1'b0;
          if (r_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: got %0h expected none", r_cur);
          end else chk("rsp_fields", r_cur, r_q.pop_front());
        end else r_pend = 1'b1;
      end else if (r_pend) begin
        checks++; errors++;
        $display("FAIL rsp_valid_drop: got 0 expected 1");
        r_pend = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic w, input logic [15:0] addr, input logic [31:0] d,
                        input logic [3:0] m, input a_t exp_a);
    int n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    a_q.push_back(exp_a);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = addr; cmd_data = d; cmd_mask = m;
    tick();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'd0; cmd_data = 32'd0; cmd_mask = 4'd0;
    chk("a_latency", tl_a_valid, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic a_accept(input int dly);
    for (int i = 0; i < dly; i++) begin
      chk("d_ready_areq", tl_d_ready, 0);
      tick();
    end
    tl_a_ready = 1'b1;
    tick();
    tl_a_ready = 1'b0;
    chk("a_done", tl_a_valid, 0);
  endtask

  task automatic d_respond(input logic [2:0] op, input logic [15:0] src, input logic [1:0] sz,
                           input logic [31:0] d, input logic [32:0] exp_r);
    r_q.push_back(exp_r);
    tl_d_valid = 1'b1; tl_d_opcode = op; tl_d_source = src; tl_d_size = sz; tl_d_data = d;
    tick();
    tl_d_valid = 1'b0;
    chk("rsp_latency", rsp_valid, 1);
  endtask

  task automatic stray_d();
    tl_d_valid = 1'b1; tl_d_opcode = 3'd1; tl_d_source = 16'(SRC); tl_d_size = 2'd2;
    tl_d_data = 32'h0BAD_0BAD;
    tick();
    tl_d_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int hs0;
    reset = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'd0; cmd_data = 32'd0; cmd_mask = 4'd0;
    tl_a_ready = 1'b0; tl_d_valid = 1'b0; tl_d_opcode = 3'd0; tl_d_size = 2'd0;
    tl_d_source = 16'd0; tl_d_data = 32'd0;
    repeat (3) tick();
    chk("rst_a_valid", tl_a_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_error", rsp_error, 0);
    reset = 1'b0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("idle_d_ready", tl_d_ready, 1);

    // Full-word write, immediate AccessAck
    do_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, mk_a(3'd0, 16'h0010, 4'hF, 32'hDEADBEEF));
    a_accept(0);
    d_respond(3'd0, 16'(SRC), 2'd2, 32'h12345678, {32'h0, 1'b0});
    tick();

    // Read with response backpressure
    do_cmd(1'b0, 16'h0024, 32'hFFFFFFFF, 4'h3, mk_a(3'd4, 16'h0024, 4'hF, 32'h0));
    a_accept(0);
    rsp_ready = 1'b0;
    d_respond(3'd1, 16'(SRC), 2'd2, 32'h000001A5, {32'h000001A5, 1'b0});
    repeat (3) tick();
    chk("rsp_hold", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    chk("rsp_release", rsp_valid, 0);

    // Partial write, A stalled 5 cycles, stray D beat during A_REQ
    do_cmd(1'b1, 16'h0013, 32'hA5A51234, 4'h3, mk_a(3'd1, 16'h0010, 4'h3, 32'hA5A51234));
    hs0 = a_hs;
    chk("d_ready_areq", tl_d_ready, 0);
    stray_d();
    a_accept(4);
    chk("a_single_hs", a_hs, hs0 + 1);
    d_respond(3'd0, 16'(SRC), 2'd2, 32'h0, {32'h0, 1'b0});
    tick();

    // Timeout: no D beat for TO cycles
    do_cmd(1'b0, 16'h0008, 32'h0, 4'hF, mk_a(3'd4, 16'h0008, 4'hF, 32'h0));
    a_accept(0);
    r_q.push_back({32'h0, 1'b1});
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("timeout_cycles", n, TO);
    tick();
    stray_d();
    repeat (3) tick();
    chk("stray_no_rsp", rsp_valid, 0);
    chk("stray_idle", cmd_ready, 1);

    // Error responses
    do_cmd(1'b0, 16'h0030, 32'h0, 4'hF, mk_a(3'd4, 16'h0030, 4'hF, 32'h0));
    a_accept(0);
    d_respond(3'd0, 16'(SRC), 2'd2, 32'h0, {32'h0, 1'b1});
    tick();
    do_cmd(1'b0, 16'h0034, 32'h0, 4'hF, mk_a(3'd4, 16'h0034, 4'hF, 32'h0));
    a_accept(0);
    d_respond(3'd1, 16'd7, 2'd2, 32'h0, {32'h0, 1'b1});
    tick();
    do_cmd(1'b0, 16'h003C, 32'h0, 4'hF, mk_a(3'd4, 16'h003C, 4'hF, 32'h0));
    a_accept(0);
    d_respond(3'd1, 16'(SRC), 2'd1, 32'h0, {32'h0, 1'b1});
    tick();
    do_cmd(1'b1, 16'h0038, 32'h11223344, 4'hF, mk_a(3'd0, 16'h0038, 4'hF, 32'h11223344));
    a_accept(0);
    d_respond(3'd1, 16'(SRC), 2'd2, 32'h99, {32'h0, 1'b1});
    tick();

    // Reset while waiting in D_WAIT, then a late responder beat
    do_cmd(1'b0, 16'h0040, 32'h0, 4'hF, mk_a(3'd4, 16'h0040, 4'hF, 32'h0));
    a_accept(0);
    reset = 1'b1;
    tick();
    chk("midrst_a_valid", tl_a_valid, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    chk("midrst_cmd_ready", cmd_ready, 1);
    stray_d();
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_rsp", rsp_valid, 0);
      tick();
    end

    // Recovery read at top of address space
    do_cmd(1'b0, 16'hFFFE, 32'h0, 4'h0, mk_a(3'd4, 16'hFFFC, 4'hF, 32'h0));
    a_accept(0);
    d_respond(3'd1, 16'(SRC), 2'd2, 32'hCAFEF00D, {32'hCAFEF00D, 1'b0});
    repeat (4) tick();

    chk("a_q_empty", a_q.size(), 0);
    chk("rsp_q_empty", r_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scumv_tuning_tl_master.md
SCUMV_TUNING_TL_MASTER -- requirements
Module: scumv_tuning_tl_master

Interface
REQ-001 Parameter SOURCE_ID, default 0: constant A-channel source and expected D-channel source.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles spent in D_WAIT before an error response.
REQ-003 clock  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid/cmd_ready  input/output  1/1  command handshake.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  16  byte address of the tuning register.
REQ-008 cmd_data, cmd_mask  input  32, 4  write data and byte mask.
REQ-009 rsp_valid/rsp_ready  output/input  1/1  response handshake.
REQ-010 rsp_data, rsp_error  output  32, 1  read data and error flag.
REQ-011 tl_a_valid/tl_a_ready  output/input  1/1  TileLink-UL A-channel handshake.
REQ-012 tl_a_opcode, tl_a_param, tl_a_size, tl_a_source  output  3, 3, 2, 16  A-channel header.
REQ-013 tl_a_address, tl_a_mask, tl_a_data, tl_a_corrupt  output  16, 4, 32, 1  A-channel payload.
REQ-014 tl_d_valid/tl_d_ready  input/output  1/1  D-channel handshake.
REQ-015 tl_d_opcode, tl_d_size, tl_d_source, tl_d_data  input  3, 2, 16, 32  D-channel response.

Function
REQ-016 FSM states SHALL be IDLE, A_REQ, D_WAIT and RSP, with exactly one transaction outstanding.
REQ-017 IDLE: cmd_ready=1; a cmd handshake SHALL register all cmd fields and enter A_REQ on the next cycle.
REQ-018 A_REQ: tl_a_valid=1 with fields held stable until tl_a_ready; on handshake enter D_WAIT; tl_a_valid never deasserts without a handshake.
REQ-019 Read SHALL issue Get (4), mask 4'hF, data 0; write SHALL issue PutFullData (0) if mask==4'hF, else PutPartialData (1).
REQ-020 tl_a_param=0, tl_a_size=2, tl_a_corrupt=0, tl_a_source=SOURCE_ID, tl_a_address={cmd_addr[15:2],2'b00} in every cycle.
REQ-021 tl_d_ready SHALL be 1 in IDLE, D_WAIT and RSP, and 0 in A_REQ; D beats arriving outside D_WAIT SHALL be discarded without effect.
REQ-022 D_WAIT: on D handshake, register tl_d_data (reads; writes give 0) and enter RSP.
REQ-023 On the D handshake, error=1 if the opcode is not the expected one (AccessAck=0 for writes, AccessAckData=1 for reads), source!=SOURCE_ID or size!=2.
REQ-024 The timeout counter SHALL clear on entering D_WAIT and increment each D_WAIT cycle without a D handshake.
REQ-025 At count==TIMEOUT_CYCLES-1 the block SHALL enter RSP with rsp_error=1 and rsp_data=0; a D handshake in that same cycle SHALL take precedence.
REQ-026 RSP: rsp_valid=1 with data/error stable until rsp_ready, then IDLE; cmd_ready=0 in every state except IDLE.
REQ-027 Latency: cmd handshake at cycle 0 gives tl_a_valid at cycle 1; D handshake at cycle n gives rsp_valid at cycle n+1.

Reset
REQ-028 While reset=1, on each rising clock edge: state=IDLE, counter=0, rsp_valid=0, tl_a_valid=0, rsp_data=0, rsp_error=0.
REQ-029 Reset mid-transaction SHALL abandon the transaction without a response; late D beats are dropped per REQ-021.
REQ-030 cmd_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-031 Package scumv_tl_pkg SHALL hold the A/D opcode constants, SIZE_WORD=2 and the FSM state typedef.
REQ-032 No sub-module is needed; the FSM, timeout counter and payload registers are local.

Verification
REQ-033 Write 0x10 data 0xDEADBEEF mask 0xF, AccessAck at once -> A opcode 0, address 0x0010, rsp_error=0, rsp_valid 1 cycle after D.
REQ-034 Read 0x24; responder returns AccessAckData 0x0000_01A5 -> A opcode 4, mask 0xF, rsp_data=0x000001A5, rsp_error=0.
REQ-035 Write mask 0x3 with tl_a_ready held low for 5 cycles -> opcode 1, A fields stable throughout, single A handshake.
REQ-036 TIMEOUT_CYCLES=8, no D response -> rsp_error=1, rsp_data=0 after 8 D_WAIT cycles; a later stray D beat is absorbed with no second response.
REQ-037 Read answered with AccessAck or wrong source -> rsp_error=1.
REQ-038 Reset asserted in D_WAIT, then responder answers -> no rsp_valid, cmd_ready=1 the cycle after reset.
